// File: rtl/mem_wb_stage.sv
// MEM/WB stage: ALU results retire 1 cycle after accept; loads hold in_ready low until dc_rvalid (or watchdog), then write aligned data.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter; otherwise instret is tied to 0.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_regwrite,
  input  logic [4:0]  in_rd,
  input  logic        in_memread,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_result,
  input  logic        flush,
  input  logic        dc_rvalid,
  input  logic [31:0] dc_rdata,
  output logic        regwrite,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        load_misaligned,
  output logic        load_timeout,
  output logic [63:0] instret
);

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [15:0] wd_q, wd_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;

  logic        accept;
  logic        misaligned;
  logic        timeout_hit;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_ready && in_valid && !flush;

  // funct3[1:0]==01 covers both LH and LHU
  assign misaligned = ((in_funct3[1:0] == 2'b01) && in_addr_lo[0]) ||
                      ((in_funct3 == 3'b010) && (in_addr_lo != 2'b00));

  assign timeout_hit = WD_EN && (state_q == WAIT_LOAD) && !dc_rvalid && (wd_q == WD_LAST);

  assign ld_byte = dc_rdata[8*lo_q +: 8];
  assign ld_half = dc_rdata[16*lo_q[1] +: 16];

  always_comb begin
    load_data = dc_rdata;
    case (f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dc_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    rw_d         = rw_q;
    f3_d         = f3_q;
    lo_d         = lo_q;
    wd_d         = wd_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    mis_d        = 1'b0;
    to_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_memread) begin
            regwrite_d = in_regwrite && (in_rd != 5'd0);
            if (regwrite_d) begin
              write_reg_d  = in_rd;
              write_data_d = in_alu_result;
            end
          end else if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            rd_d    = in_rd;
            rw_d    = in_regwrite;
            f3_d    = in_funct3;
            lo_d    = in_addr_lo;
            wd_d    = 16'd0;
            state_d = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        // a response in the watchdog's final cycle still completes normally
        if (dc_rvalid) begin
          regwrite_d = rw_q && (rd_q != 5'd0);
          if (regwrite_d) begin
            write_reg_d  = rd_q;
            write_data_d = load_data;
          end
          state_d = IDLE;
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (WD_EN) begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_q         <= 5'd0;
      rw_q         <= 1'b0;
      f3_q         <= 3'd0;
      lo_q         <= 2'd0;
      wd_q         <= 16'd0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      mis_q        <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      rw_q         <= rw_d;
      f3_q         <= f3_d;
      lo_q         <= lo_d;
      wd_q         <= wd_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      mis_q        <= mis_d;
      to_q         <= to_d;
    end
  end

  assign regwrite        = regwrite_q;
  assign write_reg       = write_reg_q;
  assign write_data      = write_data_q;
  assign load_misaligned = mis_q;
  assign load_timeout    = to_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;
  logic        complete;

  // counts retirements whether or not they write rd
  assign complete = (accept && !in_memread) || ((state_q == WAIT_LOAD) && dc_rvalid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
    end else if (complete) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stimulus pushes expected events to a scoreboard, a forked monitor checks them.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic        in_memread;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic        flush;
  logic        dc_rvalid;
  logic [31:0] dc_rdata;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        load_misaligned;
  logic        load_timeout;
  logic [63:0] instret;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_regwrite    (in_regwrite),
    .in_rd          (in_rd),
    .in_memread     (in_memread),
    .in_funct3      (in_funct3),
    .in_addr_lo     (in_addr_lo),
    .in_alu_result  (in_alu_result),
    .flush          (flush),
    .dc_rvalid      (dc_rvalid),
    .dc_rdata       (dc_rdata),
    .regwrite       (regwrite),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .load_misaligned(load_misaligned),
    .load_timeout   (load_timeout),
    .instret        (instret)
  );

  localparam logic [2:0] K_WR  = 3'b100;
  localparam logic [2:0] K_MIS = 3'b010;
  localparam logic [2:0] K_TO  = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [31:0] data;
    int unsigned cyc;
  } ev_t;

  ev_t         sb_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_instret = 64'd0;
  logic [4:0]  last_reg = 5'd0;
  logic [31:0] last_data = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] k, input logic [4:0] r, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.rd   = r;
    e.data = d;
    e.cyc  = cyc + 1;
    sb_q.push_back(e);
    if (k == K_WR) begin
      last_reg  = r;
      last_data = d;
    end
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (regwrite === 1'b1 || load_misaligned === 1'b1 || load_timeout === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: got rw=%b mis=%b to=%b reg=%0d data=0x%0h, expected no activity (cycle %0d)",
                   regwrite, load_misaligned, load_timeout, write_reg, write_data, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("event_cycle", 64'(cyc), 64'(e.cyc));
          chk("event_kind", 64'({regwrite, load_misaligned, load_timeout}), 64'(e.kind));
          if (e.kind == K_WR) begin
            chk("write_reg", 64'(write_reg), 64'(e.rd));
            chk("write_data", 64'(write_data), 64'(e.data));
          end
        end
      end
    end
  endtask

  task automatic check_instret(input string name);
`ifdef WB_INSTRET_EN
    chk(name, instret, exp_instret);
`else
    chk(name, instret, 64'd0);
`endif
  endtask

  task automatic alu(input logic rw, input logic [4:0] rd, input logic [31:0] res);
    in_valid = 1'b1; in_memread = 1'b0; in_regwrite = rw; in_rd = rd;
    in_alu_result = res; in_funct3 = 3'd0; in_addr_lo = 2'd0;
    if (rw && rd != 5'd0) push(K_WR, rd, res);
    exp_instret++;
    step();
    in_valid = 1'b0; in_alu_result = 32'd0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] lo, input logic rw, input logic [4:0] rd,
                      input int waits, input logic [31:0] rdata, input logic [31:0] exp_data);
    chk("ready_before_load", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_memread = 1'b1; in_regwrite = rw; in_rd = rd; in_funct3 = f3; in_addr_lo = lo;
    step();
    in_valid = 1'b0; in_memread = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk("ready_while_waiting", 64'(in_ready), 64'd0);
      if (i == waits - 1) begin
        dc_rvalid = 1'b1;
        dc_rdata  = rdata;
        if (rw && rd != 5'd0) push(K_WR, rd, exp_data);
      end
      step();
    end
    dc_rvalid = 1'b0; dc_rdata = 32'd0;
    chk("ready_after_response", 64'(in_ready), 64'd1);
    exp_instret++;
  endtask

  task automatic mis(input logic [2:0] f3, input logic [1:0] lo);
    in_valid = 1'b1; in_memread = 1'b1; in_regwrite = 1'b1; in_rd = 5'd3; in_funct3 = f3; in_addr_lo = lo;
    push(K_MIS, 5'd0, 32'd0);
    step();
    in_valid = 1'b0; in_memread = 1'b0;
    chk("ready_after_misaligned", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0; in_rd = 5'd0; in_memread = 1'b0;
    in_funct3 = 3'd0; in_addr_lo = 2'd0; in_alu_result = 32'd0; flush = 1'b0;
    dc_rvalid = 1'b0; dc_rdata = 32'd0;
    repeat (3) step();
    chk("reset_regwrite", 64'(regwrite), 64'd0);
    chk("reset_write_reg", 64'(write_reg), 64'd0);
    chk("reset_write_data", 64'(write_data), 64'd0);
    chk("reset_misaligned", 64'(load_misaligned), 64'd0);
    chk("reset_timeout", 64'(load_timeout), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_instret", instret, 64'd0);
    fork
      monitor();
    join_none
    rst_n = 1'b1;

    alu(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    load(3'b000, 2'd3, 1'b1, 5'd6, 3, 32'h80FF1234, 32'hFFFFFF80);
    load(3'b001, 2'd2, 1'b1, 5'd7, 1, 32'h80010000, 32'hFFFF8001);
    load(3'b101, 2'd2, 1'b1, 5'd8, 2, 32'h80010000, 32'h00008001);
    load(3'b100, 2'd1, 1'b1, 5'd9, 1, 32'h80FF1234, 32'h00000012);
    load(3'b000, 2'd2, 1'b1, 5'd10, 1, 32'h80FF1234, 32'hFFFFFFFF);
    load(3'b001, 2'd0, 1'b1, 5'd11, 1, 32'h1234F00D, 32'hFFFFF00D);
    load(3'b010, 2'd0, 1'b1, 5'd12, 2, 32'hCAFEF00D, 32'hCAFEF00D);
    alu(1'b1, 5'd13, 32'h0000_0042);
    check_instret("instret_mid");

    mis(3'b010, 2'd1);
    mis(3'b001, 2'd1);
    mis(3'b101, 2'd3);
    load(3'b010, 2'd0, 1'b1, 5'd0, 1, 32'h11111111, 32'h0);
    load(3'b010, 2'd0, 1'b0, 5'd4, 2, 32'h22222222, 32'h0);
    alu(1'b0, 5'd14, 32'h33333333);
    alu(1'b1, 5'd0, 32'h44444444);
    step();
    chk("hold_write_reg", 64'(write_reg), 64'(last_reg));
    chk("hold_write_data", 64'(write_data), 64'(last_data));
    check_instret("instret_after_nowrite");

    // watchdog expiry, then a late response that must be ignored in IDLE
    in_valid = 1'b1; in_memread = 1'b1; in_regwrite = 1'b1; in_rd = 5'd15; in_funct3 = 3'b010; in_addr_lo = 2'd0;
    step();
    in_valid = 1'b0; in_memread = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ready_before_timeout", 64'(in_ready), 64'd0);
      if (i == 3) push(K_TO, 5'd0, 32'd0);
      step();
    end
    chk("ready_after_timeout", 64'(in_ready), 64'd1);
    dc_rvalid = 1'b1; dc_rdata = 32'h55555555;
    step();
    dc_rvalid = 1'b0;
    load(3'b010, 2'd0, 1'b1, 5'd16, 4, 32'h66666666, 32'h66666666);
    check_instret("instret_after_timeout");

    in_valid = 1'b1; flush = 1'b1; in_regwrite = 1'b1; in_rd = 5'd17; in_alu_result = 32'h77777777;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("ready_after_flush", 64'(in_ready), 64'd1);
    step();
    chk("flush_hold_data", 64'(write_data), 64'(last_data));
    check_instret("instret_after_flush");

    // reset while a load is pending
    in_valid = 1'b1; in_memread = 1'b1; in_regwrite = 1'b1; in_rd = 5'd18; in_funct3 = 3'b010; in_addr_lo = 2'd0;
    step();
    in_valid = 1'b0; in_memread = 1'b0;
    chk("ready_pending_load", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_instret = 64'd0; last_reg = 5'd0; last_data = 32'd0;
    dc_rvalid = 1'b1; dc_rdata = 32'h88888888;
    step();
    dc_rvalid = 1'b0;
    step();
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_write_reg", 64'(write_reg), 64'd0);
    chk("midreset_write_data", 64'(write_data), 64'd0);
    check_instret("midreset_instret");

    alu(1'b1, 5'd1, 32'h00000001);
    alu(1'b1, 5'd2, 32'h00000002);
    in_valid = 1'b1; flush = 1'b1; in_regwrite = 1'b1; in_rd = 5'd19; in_alu_result = 32'h99999999;
    step();
    in_valid = 1'b0; flush = 1'b0;
    alu(1'b1, 5'd3, 32'h00000003);
    step();
    check_instret("instret_three_ops");

    repeat (3) step();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
